// File: rtl/prog_loader.sv
// Byte-serial program loader: assembles big-endian byte pairs into instruction
// words, writes them to instruction memory and holds the core until an HLT word lands.
module prog_loader #(
   parameter int INSN_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int MAX_WORDS  = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [INSN_WIDTH-1:0] mem_wdata,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH-1:0] word_count
);

   localparam logic [ADDR_WIDTH-1:0] START_ADDRESS = '0;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDRESS  = ADDR_WIDTH'(MAX_WORDS - 1);
   localparam logic [INSN_WIDTH-1:0] INSN_HLT      = '0;

   typedef enum logic [2:0] {IDLE, HIGH, LOW, WRITE, DONE, ERROR} state_t;

   state_t state;
   state_t state_next;
   logic   transfer;
   logic   is_hlt;
   logic   at_last;

   assign transfer = byte_valid & byte_ready;
   assign is_hlt   = (mem_wdata == INSN_HLT);
   assign at_last  = (mem_addr == LAST_ADDRESS);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Status outputs decode straight from the state so reset clears them immediately.
   always_comb begin
      state_next = state;
      byte_ready = 1'b0;
      mem_we     = 1'b0;
      cpu_hold   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = HIGH;
         end
         HIGH: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            cpu_hold   = 1'b1;
            if (transfer) state_next = LOW;
         end
         LOW: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            cpu_hold   = 1'b1;
            if (transfer) state_next = WRITE;
         end
         WRITE: begin
            mem_we   = 1'b1;
            busy     = 1'b1;
            cpu_hold = 1'b1;
            if (is_hlt)       state_next = DONE;
            else if (at_last) state_next = ERROR;
            else              state_next = HIGH;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_next = HIGH;
         end
         ERROR: begin
            error    = 1'b1;
            cpu_hold = 1'b1;
            if (start) state_next = HIGH;
         end
         default: state_next = IDLE;
      endcase
   end

   // The address only advances when another word will follow, so it never passes the last slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_addr   <= '0;
         mem_wdata  <= '0;
         word_count <= '0;
      end else begin
         case (state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  mem_addr   <= START_ADDRESS;
                  word_count <= '0;
               end
            end
            HIGH: begin
               if (transfer) mem_wdata[INSN_WIDTH-1 -: 8] <= byte_data;
            end
            LOW: begin
               if (transfer) mem_wdata[7:0] <= byte_data;
            end
            WRITE: begin
               word_count <= word_count + 1'b1;
               if (!is_hlt && !at_last) mem_addr <= mem_addr + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a 4-word memory; a write log and shadow
// memory are built from mem_we strobes and compared against hand-derived images.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] word_count;

   int          n_checks = 0;
   int          n_fail = 0;
   int          wr_n = 0;
   logic [15:0] wr_addr [0:15];
   logic [15:0] wr_data [0:15];
   logic [15:0] model_mem [0:3];

   prog_loader #(.INSN_WIDTH(16), .ADDR_WIDTH(16), .MAX_WORDS(4)) dut (
      .clk(clk), .reset(reset), .start(start),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
      .word_count(word_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) begin
         if (wr_n < 16) begin
            wr_addr[wr_n] = mem_addr;
            wr_data[wr_n] = mem_wdata;
         end
         wr_n = wr_n + 1;
         model_mem[mem_addr[1:0]] = mem_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Presents one byte and returns on the negedge after the edge that accepted it.
   task automatic send_byte(input logic [7:0] b);
      int n;
      byte_valid = 1'b1;
      byte_data  = b;
      n = 0;
      while (!byte_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", {31'd0, byte_ready}, 32'd1);
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] w);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic wait_end();
      int n;
      n = 0;
      while (!(done || error) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("end_wait", {31'd0, (done || error)}, 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) model_mem[i] = 16'hDEAD;

      // Reset values
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
      check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
      check("rst_flags", {28'd0, cpu_hold, busy, done, error}, 32'd0);
      check("rst_word_count", {16'd0, word_count}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("idle_ready", {31'd0, byte_ready}, 32'd0);

      // Basic image 12 34 00 01 00 00
      pulse_start();
      check("high_flags", {29'd0, byte_ready, busy, cpu_hold}, 32'h7);
      check("high_addr", {16'd0, mem_addr}, 32'd0);
      send_byte(8'h12);
      send_byte(8'h34);
      check("w0_we", {31'd0, mem_we}, 32'd1);
      check("w0_addr", {16'd0, mem_addr}, 32'd0);
      check("w0_data", {16'd0, mem_wdata}, 32'h1234);
      check("w0_ready", {31'd0, byte_ready}, 32'd0);
      send_word(16'h0001);
      send_word(16'h0000);
      wait_end();
      check("b_writes", wr_n, 32'd3);
      check("b_wr0", {wr_addr[0], wr_data[0]}, {16'd0, 16'h1234});
      check("b_wr1", {wr_addr[1], wr_data[1]}, {16'd1, 16'h0001});
      check("b_wr2", {wr_addr[2], wr_data[2]}, {16'd2, 16'h0000});
      check("b_done_flags", {28'd0, done, error, busy, cpu_hold}, 32'h8);
      check("b_word_count", {16'd0, word_count}, 32'd3);

      // Same image with byte_valid toggling; ignored bytes carry junk
      wr_n = 0;
      pulse_start();
      check("t_done_cleared", {31'd0, done}, 32'd0);
      send_byte(8'h12);
      byte_data = 8'hFF;
      @(negedge clk);
      check("t_stall_low", {29'd0, byte_ready, mem_we, busy}, 32'h5);
      check("t_stall_hi", {24'd0, mem_wdata[15:8]}, 32'h12);
      send_byte(8'h34); byte_data = 8'hFF; @(negedge clk);
      send_byte(8'h00); byte_data = 8'hFF; @(negedge clk);
      send_byte(8'h01); byte_data = 8'hFF; @(negedge clk);
      send_byte(8'h00); byte_data = 8'hFF; @(negedge clk);
      send_byte(8'h00);
      wait_end();
      check("t_writes", wr_n, 32'd3);
      check("t_wr0", {wr_addr[0], wr_data[0]}, {16'd0, 16'h1234});
      check("t_wr1", {wr_addr[1], wr_data[1]}, {16'd1, 16'h0001});
      check("t_wr2", {wr_addr[2], wr_data[2]}, {16'd2, 16'h0000});
      check("t_word_count", {16'd0, word_count}, 32'd3);

      // Restart from DONE with a lone HLT; start pulses mid-load are ignored
      wr_n = 0;
      pulse_start();
      pulse_start();
      send_byte(8'h00);
      pulse_start();
      check("s_still_low", {31'd0, byte_ready}, 32'd1);
      send_byte(8'h00);
      wait_end();
      check("s_writes", wr_n, 32'd1);
      check("s_wr0", {wr_addr[0], wr_data[0]}, 32'd0);
      check("s_done", {30'd0, done, error}, 32'h2);
      check("s_word_count", {16'd0, word_count}, 32'd1);

      // Overflow of the 4-word memory
      wr_n = 0;
      pulse_start();
      send_word(16'hA001);
      send_word(16'hA002);
      send_word(16'hA003);
      send_word(16'hA004);
      wait_end();
      check("o_flags", {28'd0, done, error, busy, cpu_hold}, 32'h5);
      check("o_writes", wr_n, 32'd4);
      check("o_wr3", {wr_addr[3], wr_data[3]}, {16'd3, 16'hA004});
      check("o_word_count", {16'd0, word_count}, 32'd4);
      check("o_addr", {16'd0, mem_addr}, 32'd3);
      byte_valid = 1'b1;
      byte_data  = 8'hA0;
      repeat (5) @(negedge clk);
      check("o_fifth_ready", {31'd0, byte_ready}, 32'd0);
      byte_valid = 1'b0;
      check("o_fifth_writes", wr_n, 32'd4);
      check("o_still_error", {30'd0, error, cpu_hold}, 32'h3);

      // Restart from ERROR, then reset while waiting for word 1 low byte
      wr_n = 0;
      pulse_start();
      check("r_restart", {28'd0, error, busy, done, cpu_hold}, 32'h5);
      check("r_restart_cnt", {mem_addr, word_count}, 32'd0);
      send_word(16'h1111);
      send_byte(8'h22);
      reset = 1'b1;
      #1;
      check("r_flags", {26'd0, byte_ready, mem_we, cpu_hold, busy, done, error}, 32'd0);
      check("r_addr_data", {mem_addr, mem_wdata}, 32'd0);
      check("r_word_count", {16'd0, word_count}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("r_writes", wr_n, 32'd1);
      check("r_mem1", {16'd0, model_mem[1]}, 32'hA002);
      check("r_mem0", {16'd0, model_mem[0]}, 32'h1111);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
